// File: rtl/riscv_pkg.sv
// Shared RV32I decode helpers: opcode/funct3 constants, instruction class, immediate extraction.
package riscv_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        INSTR_SEQ,
        INSTR_BRANCH,
        INSTR_JAL,
        INSTR_JALR
    } instr_kind_e;

    function automatic instr_kind_e decode_kind(input logic [6:0] opc);
        instr_kind_e kind;
        kind = INSTR_SEQ;
        case (opc)
            OPC_BRANCH: kind = INSTR_BRANCH;
            OPC_JAL:    kind = INSTR_JAL;
            OPC_JALR:   kind = INSTR_JALR;
            default:    kind = INSTR_SEQ;
        endcase
        return kind;
    endfunction

    function automatic logic [ILEN-1:0] imm_b(input logic [ILEN-1:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [ILEN-1:0] imm_j(input logic [ILEN-1:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [ILEN-1:0] imm_i(input logic [ILEN-1:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Decode/compare side to PC unit bundle; master drives the instruction, slave owns the PC.
interface pc_next_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      Instruccion;
    logic             instr_valid;
    logic             stall;
    logic             trap_req;
    logic [XLEN-1:0]  rs1_val;
    logic             Cero;
    logic             lt;
    logic             ltu;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  link_addr;
    logic             taken;
    logic             flush;
    logic             misaligned;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output Instruccion, instr_valid, stall, trap_req, rs1_val, Cero, lt, ltu,
        input  pc, link_addr, taken, flush, misaligned, branch_cnt, taken_cnt
    );

    modport slave (
        input  Instruccion, instr_valid, stall, trap_req, rs1_val, Cero, lt, ltu,
        output pc, link_addr, taken, flush, misaligned, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational RV32I branch condition from funct3 and the comparator flags.
module branch_cond_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       cero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       cond_c_o
);

    // funct3 010/011 are reserved encodings and never redirect
    always_comb begin
        cond_c_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_c_o = cero_i;
            F3_BNE:  cond_c_o = ~cero_i;
            F3_BLT:  cond_c_o = lt_i;
            F3_BGE:  cond_c_o = ~lt_i;
            F3_BLTU: cond_c_o = ltu_i;
            F3_BGEU: cond_c_o = ~ltu_i;
            default: cond_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with branch/jump/trap next-PC selection,
// misaligned-target fault and saturating branch statistics.
module pc_next_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_next_unit_if.slave pc_if
);

    instr_kind_e      kind_c;
    logic             cond_c;
    logic             taken_c;
    logic             misalign_c;
    logic             count_en_c;
    logic [XLEN-1:0]  seq_pc_c;
    logic [XLEN-1:0]  jalr_sum_c;
    logic [XLEN-1:0]  target_c;

    logic [XLEN-1:0]  pc_q,       pc_d;
    logic             flush_q,    flush_d;
    logic             mis_q,      mis_d;
    logic [CNT_W-1:0] br_cnt_q,   br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q,   tk_cnt_d;

    assign kind_c = decode_kind(pc_if.Instruccion[6:0]);

    branch_cond_eval u_cond (
        .funct3_i (pc_if.Instruccion[14:12]),
        .cero_i   (pc_if.Cero),
        .lt_i     (pc_if.lt),
        .ltu_i    (pc_if.ltu),
        .cond_c_o (cond_c)
    );

    assign seq_pc_c   = pc_q + XLEN'(4);
    assign jalr_sum_c = pc_if.rs1_val + XLEN'($signed(imm_i(pc_if.Instruccion)));

    // Redirect target; all sums wrap modulo 2^XLEN
    always_comb begin
        target_c = seq_pc_c;
        case (kind_c)
            INSTR_BRANCH: target_c = pc_q + XLEN'($signed(imm_b(pc_if.Instruccion)));
            INSTR_JAL:    target_c = pc_q + XLEN'($signed(imm_j(pc_if.Instruccion)));
            INSTR_JALR:   target_c = {jalr_sum_c[XLEN-1:1], 1'b0};
            default:      target_c = seq_pc_c;
        endcase
    end

    assign taken_c = pc_if.instr_valid &
                     ((kind_c == INSTR_JAL) | (kind_c == INSTR_JALR) |
                      ((kind_c == INSTR_BRANCH) & cond_c));
    assign misalign_c = (target_c[1:0] != 2'b00);
    assign count_en_c = pc_if.instr_valid & ~pc_if.stall & ~pc_if.trap_req &
                        (kind_c == INSTR_BRANCH);

    // Next-PC priority: trap > stall > invalid > misaligned > taken > sequential
    always_comb begin
        pc_d     = pc_q;
        flush_d  = 1'b0;
        mis_d    = 1'b0;
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;

        if (pc_if.trap_req) begin
            pc_d    = TRAP_VECTOR;
            flush_d = 1'b1;
        end else if (pc_if.stall || !pc_if.instr_valid) begin
            pc_d = pc_q;
        end else if (taken_c && misalign_c) begin
            pc_d    = TRAP_VECTOR;
            mis_d   = 1'b1;
            flush_d = 1'b1;
        end else if (taken_c) begin
            pc_d    = target_c;
            flush_d = 1'b1;
        end else begin
            pc_d = seq_pc_c;
        end

        // Saturating statistics; a misaligned taken branch still counts as taken
        if (count_en_c) begin
            if (br_cnt_q != {CNT_W{1'b1}}) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (cond_c && (tk_cnt_q != {CNT_W{1'b1}})) begin
                tk_cnt_d = tk_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_VECTOR;
            flush_q  <= 1'b0;
            mis_q    <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            mis_q    <= mis_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign pc_if.pc         = pc_q;
    assign pc_if.link_addr  = seq_pc_c;
    assign pc_if.taken      = taken_c;
    assign pc_if.flush      = flush_q;
    assign pc_if.misaligned = mis_q;
    assign pc_if.branch_cnt = br_cnt_q;
    assign pc_if.taken_cnt  = tk_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: vector table plus hand-written multi-cycle sequences.
module tb_pc_next_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BNE_M8 = 32'hFE00_1CE3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_next_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) pc_if ();

    pc_next_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_if (pc_if)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic        c, l, lu;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic v, input logic st, input logic tr,
                         input logic [31:0] rs1, input logic c, input logic l, input logic lu);
        pc_if.Instruccion = instr;
        pc_if.instr_valid = v;
        pc_if.stall       = st;
        pc_if.trap_req    = tr;
        pc_if.rs1_val     = rs1;
        pc_if.Cero        = c;
        pc_if.lt          = l;
        pc_if.ltu         = lu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] off);
        return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    // Jump anywhere through a JALR with zero offset (no branch, so counters untouched)
    task automatic goto_pc(input logic [31:0] a);
        drive(enc_jalr(12'h000), 1'b1, 1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    function automatic void add(input string n, input logic [31:0] spc, input logic [31:0] ins,
                                input logic [31:0] rs1, input logic c, input logic l, input logic lu,
                                input logic tk, input logic [31:0] epc, input logic fl, input logic mi);
        vec_t v;
        v.name = n; v.start_pc = spc; v.instr = ins; v.rs1 = rs1;
        v.c = c; v.l = l; v.lu = lu;
        v.exp_taken = tk; v.exp_pc = epc; v.exp_flush = fl; v.exp_mis = mi;
        vecs.push_back(v);
    endfunction

    initial begin
        // Comparator pattern (0,1,0) at 0x200, offset +16
        add("beq_010",   32'h200, enc_b(3'b000, 13'd16), 0, 0, 1, 0, 0, 32'h204, 0, 0);
        add("bne_010",   32'h200, enc_b(3'b001, 13'd16), 0, 0, 1, 0, 1, 32'h210, 1, 0);
        add("f3_2_010",  32'h200, enc_b(3'b010, 13'd16), 0, 0, 1, 0, 0, 32'h204, 0, 0);
        add("f3_3_010",  32'h200, enc_b(3'b011, 13'd16), 0, 0, 1, 0, 0, 32'h204, 0, 0);
        add("blt_010",   32'h200, enc_b(3'b100, 13'd16), 0, 0, 1, 0, 1, 32'h210, 1, 0);
        add("bge_010",   32'h200, enc_b(3'b101, 13'd16), 0, 0, 1, 0, 0, 32'h204, 0, 0);
        add("bltu_010",  32'h200, enc_b(3'b110, 13'd16), 0, 0, 1, 0, 0, 32'h204, 0, 0);
        add("bgeu_010",  32'h200, enc_b(3'b111, 13'd16), 0, 0, 1, 0, 1, 32'h210, 1, 0);
        // Complementary pattern (1,0,1) at 0x300, offset -16
        add("beq_101",   32'h300, enc_b(3'b000, -13'sd16), 0, 1, 0, 1, 1, 32'h2F0, 1, 0);
        add("bge_101",   32'h300, enc_b(3'b101, -13'sd16), 0, 1, 0, 1, 1, 32'h2F0, 1, 0);
        add("bltu_101",  32'h300, enc_b(3'b110, -13'sd16), 0, 1, 0, 1, 1, 32'h2F0, 1, 0);
        add("bgeu_101",  32'h300, enc_b(3'b111, -13'sd16), 0, 1, 0, 1, 0, 32'h304, 0, 0);
        // Signed vs unsigned disagreement
        add("blt_001",   32'h400, enc_b(3'b100, 13'd8), 0, 0, 0, 1, 0, 32'h404, 0, 0);
        add("bltu_001",  32'h400, enc_b(3'b110, 13'd8), 0, 0, 0, 1, 1, 32'h408, 1, 0);
        // Jumps, wrap-around and misaligned targets
        add("jal_p800",  32'h1000, enc_j(21'h800), 0, 0, 0, 0, 1, 32'h1800, 1, 0);
        add("jal_wrap",  32'h0, enc_j(-21'sd4), 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        add("jalr_mis",  32'h40, enc_jalr(12'h000), 32'h2003, 0, 0, 0, 1, TV, 1, 1);
        add("jalr_b0",   32'h40, enc_jalr(12'hFFC), 32'h1001, 0, 0, 0, 1, 32'h0FFC, 1, 0);
        add("br_mis",    32'h500, enc_b(3'b000, 13'd2), 0, 1, 0, 0, 1, TV, 1, 1);
        add("br_wrap",   32'hFFFF_FFF8, enc_b(3'b001, 13'd16), 0, 0, 0, 0, 1, 32'h8, 1, 0);
        add("alu_seq",   32'h600, 32'h0020_81B3, 0, 1, 1, 1, 0, 32'h604, 0, 0);

        // Reset state
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_if.pc, RV);
        chk("rst_flush", 32'(pc_if.flush), 0);
        chk("rst_mis", 32'(pc_if.misaligned), 0);
        chk("rst_bcnt", 32'(pc_if.branch_cnt), 0);
        chk("rst_tcnt", 32'(pc_if.taken_cnt), 0);
        rst_n = 1'b1;

        // Sequential NOPs
        drive(NOP, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("nop_pc%0d", i), pc_if.pc, 32'(4 * i));
            chk($sformatf("nop_flush%0d", i), 32'(pc_if.flush), 0);
        end

        // BNE -8 at 0x100, taken then not taken
        drive(NOP, 0, 0, 1, 0, 0, 0, 0);
        step();
        chk("trap_pc", pc_if.pc, TV);
        chk("trap_flush", 32'(pc_if.flush), 1);
        drive(BNE_M8, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("bne_taken_c", 32'(pc_if.taken), 1);
        step();
        chk("bne_pc", pc_if.pc, 32'hF8);
        chk("bne_flush", 32'(pc_if.flush), 1);
        chk("bne_bcnt", 32'(pc_if.branch_cnt), 1);
        chk("bne_tcnt", 32'(pc_if.taken_cnt), 1);
        idle();
        step();
        chk("bne_flush_drop", 32'(pc_if.flush), 0);
        chk("invalid_hold", pc_if.pc, 32'hF8);
        drive(NOP, 0, 0, 1, 0, 0, 0, 0);
        step();
        drive(BNE_M8, 1, 0, 0, 0, 1, 0, 0);
        step();
        chk("bne_nt_pc", pc_if.pc, 32'h104);
        chk("bne_nt_flush", 32'(pc_if.flush), 0);
        chk("bne_nt_bcnt", 32'(pc_if.branch_cnt), 2);
        chk("bne_nt_tcnt", 32'(pc_if.taken_cnt), 1);

        // Stall with a taken BEQ presented, then trap during stall
        drive(enc_b(3'b000, 13'd16), 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_pc%0d", i), pc_if.pc, 32'h104);
            chk($sformatf("stall_flush%0d", i), 32'(pc_if.flush), 0);
            chk($sformatf("stall_bcnt%0d", i), 32'(pc_if.branch_cnt), 2);
            chk($sformatf("stall_tcnt%0d", i), 32'(pc_if.taken_cnt), 1);
        end
        drive(enc_b(3'b000, 13'd16), 1, 1, 1, 0, 1, 0, 0);
        step();
        chk("stall_trap_pc", pc_if.pc, TV);
        chk("stall_trap_flush", 32'(pc_if.flush), 1);
        chk("stall_trap_bcnt", 32'(pc_if.branch_cnt), 2);
        idle();
        step();
        chk("trap_pulse_end", 32'(pc_if.flush), 0);

        // Misaligned pulse lasts one cycle
        goto_pc(32'h40);
        drive(enc_jalr(12'h000), 1, 0, 0, 32'h2003, 0, 0, 0);
        step();
        chk("mis_set", 32'(pc_if.misaligned), 1);
        idle();
        step();
        chk("mis_clear", 32'(pc_if.misaligned), 0);
        chk("mis_flush_clear", 32'(pc_if.flush), 0);
        chk("mis_pc_hold", pc_if.pc, TV);

        // Vector table
        foreach (vecs[k]) begin
            goto_pc(vecs[k].start_pc);
            drive(vecs[k].instr, 1, 0, 0, vecs[k].rs1, vecs[k].c, vecs[k].l, vecs[k].lu);
            #1;
            chk({vecs[k].name, "_taken"}, 32'(pc_if.taken), 32'(vecs[k].exp_taken));
            chk({vecs[k].name, "_link"}, pc_if.link_addr, vecs[k].start_pc + 32'd4);
            step();
            chk({vecs[k].name, "_pc"}, pc_if.pc, vecs[k].exp_pc);
            chk({vecs[k].name, "_flush"}, 32'(pc_if.flush), 32'(vecs[k].exp_flush));
            chk({vecs[k].name, "_mis"}, 32'(pc_if.misaligned), 32'(vecs[k].exp_mis));
        end

        // Saturation with back-to-back taken branches
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(enc_b(3'b000, 13'd4), 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("b2b_flush%0d", i), 32'(pc_if.flush), 1);
            chk($sformatf("b2b_pc%0d", i), pc_if.pc, 32'(4 * (i + 1)));
            if (i == 14) begin
                chk("sat_reach_bcnt", 32'(pc_if.branch_cnt), 15);
                chk("sat_reach_tcnt", 32'(pc_if.taken_cnt), 15);
            end
        end
        chk("sat_hold_bcnt", 32'(pc_if.branch_cnt), 15);
        chk("sat_hold_tcnt", 32'(pc_if.taken_cnt), 15);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_if.pc, RV);
        chk("arst_flush", 32'(pc_if.flush), 0);
        chk("arst_bcnt", 32'(pc_if.branch_cnt), 0);
        chk("arst_tcnt", 32'(pc_if.taken_cnt), 0);
        step();
        chk("arst_held_pc", pc_if.pc, RV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
